vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised successor of the fixed 640x480 sync generator.
- Generates VGA/DVI raster timing with:
  - an internal pixel-clock-enable divider, so a 50 MHz or faster system clock can drive a 25 MHz raster;
  - selectable sync polarity per axis;
  - a programmable pixel-pipeline delay on the sync and display-enable outputs;
  - a frame counter;
  - line-start, frame-start and vblank-start strobes.
- Sits between `clk`/`reset` and the pixel renderer in the tt_um top level. It feeds the TinyVGA PMOD mapping.

Parameters:
- H_DISPLAY, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_DISPLAY, 480, visible lines
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- H_SYNC_POL, 0, 1 = hsync active-high, 0 = active-low
- V_SYNC_POL, 0, 1 = vsync active-high, 0 = active-low
- CLK_DIV, 1, clk cycles per pixel (>=1)
- PIPE_DELAY, 0, pixel ticks of delay on hsync/vsync/display_on (0..15)
- FRAME_W, 8, frame counter width
- POS_W, 10, hpos/vpos width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk, input, 1, system clock
- reset, input, 1, synchronous active-high reset
- en, input, 1, run enable; low freezes the divider and all counters
- pix_en, output, 1, one-clk pixel tick strobe
- hpos, output, POS_W, current horizontal counter (undelayed)
- vpos, output, POS_W, current vertical counter (undelayed)
- hsync, output, 1, delayed, polarity-applied hsync
- vsync, output, 1, delayed, polarity-applied vsync
- display_on, output, 1, delayed visible-area flag
- line_start, output, 1, one-clk strobe: pix_en while hpos==0
- frame_start, output, 1, one-clk strobe: pix_en while hpos==0 and vpos==0
- vblank_start, output, 1, one-clk strobe: pix_en while hpos==0 and vpos==V_DISPLAY
- frame_cnt, output, FRAME_W, completed-frame count

Behaviour:
- Totals:
  - H_TOTAL = sum of the four H parameters.
  - V_TOTAL = sum of the four V parameters.
- Divider:
  - div_cnt counts 0..CLK_DIV-1 while en=1; it holds while en=0.
  - pix_en = en && div_cnt==CLK_DIV-1. With CLK_DIV=1, pix_en = en.
  - After reset, the first pix_en occurs in clk cycle CLK_DIV-1 (cycle 0 = first cycle with reset low and en high).
- Counters update only on clk edges where pix_en=1:
  - hpos == H_TOTAL-1: hpos <= 0. vpos advances.
  - Otherwise: hpos <= hpos+1.
  - vpos == V_TOTAL-1 on an advance: vpos <= 0 and frame_cnt <= frame_cnt+1. frame_cnt wraps modulo 2^FRAME_W.
- Raw decode (combinational from hpos/vpos):
  - hs_raw = H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC
  - vs_raw = V_DISPLAY+V_FRONT <= vpos < V_DISPLAY+V_FRONT+V_SYNC
  - de_raw = hpos<H_DISPLAY && vpos<V_DISPLAY
  - The vertical sync window is decoded on vpos only. vsync edges therefore coincide with hpos==0.
- Polarity: hsync level = hs_raw XNOR H_SYNC_POL; vsync likewise with V_SYNC_POL. The inactive level is the inverse of POL.
- Delay:
  - PIPE_DELAY=0: outputs are the combinational decode.
  - PIPE_DELAY=N>0: an N-stage shift register shifts only on pix_en. Output equals the decode from N pixel ticks earlier.
  - hpos/vpos and the strobes are never delayed.
- Strobes are combinational from pix_en and the counter values, so they are high in the same clk cycle as the qualifying pix_en.
- Reset (synchronous, dominant over en):
  - div_cnt, hpos, vpos, frame_cnt = 0.
  - Every delay stage loads hsync/vsync inactive level and display_on=0.
  - pix_en and strobes: 0 during reset.
  - Reset mid-frame restarts at (0,0) on the next cycle.
  - The first pix_en after reset produces frame_start=1 and line_start=1.
- en low mid-line: hpos/vpos/outputs hold their exact values. No strobe is generated. Resuming continues without a skipped or repeated pixel.
- Simultaneous events: on the pixel tick at hpos=0, vpos=0, both frame_start and line_start are high. vblank_start and frame_start are never simultaneous (V_DISPLAY>0).

Decomposition:
- vga_timing_pkg: localparam sets for 640x480@60 (defaults) and 800x600@60 (40/128/88 H porches/sync, 1/4/23 V).
- vga_timing_pkg also holds a helper constant function for H_TOTAL/V_TOTAL.
- One sub-module: vga_sync_delay. It is a parametrised N-stage, 3-bit shift register with a shift-enable and a reset value input, and it is bypassed when N=0.

Test Plan:
- Tiny timing for all tests: H 8/2/2/2 (H_TOTAL 14), V 4/1/1/1 (V_TOTAL 7).
- CLK_DIV=2, PIPE_DELAY=0, POL=1, reset then en=1 -> pix_en in clk cycles 1,3,5… hsync high for hpos 10..11; vsync high for vpos 5; display_on for hpos<8 and vpos<4; frame_start every 196 clks.
- POL=0, PIPE_DELAY=2, CLK_DIV=1 -> hsync low exactly when hpos is 12..13 (raw window shifted by 2 ticks); display_on high for hpos 2..9 on lines 0..3; idle level 1 immediately after reset.
- Run 256 frames with FRAME_W=8 -> frame_cnt reaches 255, then wraps to 0 on vpos 6->0; vblank_start pulses once per frame at vpos=4, hpos=0.
- Drop en for 5 clks at hpos=5, vpos=2 -> all outputs hold, no strobes; after resume, next pixel is hpos=6.
- Assert reset for 1 clk at hpos=11, vpos=5 -> next cycle hpos=0, vpos=0, frame_cnt=0, hsync/vsync inactive; first pix_en gives frame_start=line_start=1.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared timing presets and helpers for the VGA raster generator.
// The defaults are 640x480@60; an 800x600@60 set is provided as an alternative.
package vga_timing_pkg;

  localparam int VGA640_H_DISPLAY = 640;
  localparam int VGA640_H_FRONT   = 16;
  localparam int VGA640_H_SYNC    = 96;
  localparam int VGA640_H_BACK    = 48;
  localparam int VGA640_V_DISPLAY = 480;
  localparam int VGA640_V_FRONT   = 10;
  localparam int VGA640_V_SYNC    = 2;
  localparam int VGA640_V_BACK    = 33;

  localparam int SVGA800_H_DISPLAY = 800;
  localparam int SVGA800_H_FRONT   = 40;
  localparam int SVGA800_H_SYNC    = 128;
  localparam int SVGA800_H_BACK    = 88;
  localparam int SVGA800_V_DISPLAY = 600;
  localparam int SVGA800_V_FRONT   = 1;
  localparam int SVGA800_V_SYNC    = 4;
  localparam int SVGA800_V_BACK    = 23;

  // Bundle of the three pixel-aligned signals carried through the delay line.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } sync_bits_t;

  function automatic int axis_total(input int display, input int front,
                                    input int sync, input int back);
    return display + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster-timing bundle between the generator (master) and the pixel renderer (slave).
// pix_en qualifies every pixel; hpos/vpos are valid whenever pix_en is high.
interface vga_timing_gen_if #(
  parameter int POS_W   = 10,
  parameter int FRAME_W = 8
);
  logic               en;
  logic               pix_en;
  logic [POS_W-1:0]   hpos;
  logic [POS_W-1:0]   vpos;
  logic               hsync;
  logic               vsync;
  logic               display_on;
  logic               line_start;
  logic               frame_start;
  logic               vblank_start;
  logic [FRAME_W-1:0] frame_cnt;

  modport master (
    input  en,
    output pix_en, hpos, vpos, hsync, vsync, display_on,
           line_start, frame_start, vblank_start, frame_cnt
  );

  modport slave (
    output en,
    input  pix_en, hpos, vpos, hsync, vsync, display_on,
           line_start, frame_start, vblank_start, frame_cnt
  );
endinterface

// File: rtl/vga_sync_delay.sv
// N-stage shift register advancing only on shift_en_i; N=0 is a straight wire.
// Reset loads every stage with rst_val_i so the outputs start at their idle levels.
module vga_sync_delay #(
  parameter int N = 0,
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         shift_en_i,
  input  logic [W-1:0] rst_val_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  generate
    if (N == 0) begin : g_bypass
      logic unused_bypass;
      assign unused_bypass = ^{clk, reset, shift_en_i, rst_val_i};
      assign q_o = d_i;
    end else begin : g_pipe
      logic [W-1:0] stage_q [N];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < N; i++) stage_q[i] <= rst_val_i;
        end else if (shift_en_i) begin
          stage_q[0] <= d_i;
          for (int i = 1; i < N; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign q_o = stage_q[N-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA/DVI raster timing generator with pixel-clock divider,
// per-axis sync polarity, pixel-pipeline delay, frame counter and position strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY  = VGA640_H_DISPLAY,
  parameter int H_FRONT    = VGA640_H_FRONT,
  parameter int H_SYNC     = VGA640_H_SYNC,
  parameter int H_BACK     = VGA640_H_BACK,
  parameter int V_DISPLAY  = VGA640_V_DISPLAY,
  parameter int V_FRONT    = VGA640_V_FRONT,
  parameter int V_SYNC     = VGA640_V_SYNC,
  parameter int V_BACK     = VGA640_V_BACK,
  parameter int H_SYNC_POL = 0,
  parameter int V_SYNC_POL = 0,
  parameter int CLK_DIV    = 1,
  parameter int PIPE_DELAY = 0,
  parameter int FRAME_W    = 8,
  parameter int POS_W      = 10
) (
  input  logic              clk,
  input  logic              reset,
  vga_timing_gen_if.master  vga
);

  localparam int H_TOTAL = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = axis_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [POS_W-1:0] H_LAST   = POS_W'(H_TOTAL - 1);
  localparam logic [POS_W-1:0] V_LAST   = POS_W'(V_TOTAL - 1);
  localparam logic [POS_W-1:0] H_DISP   = POS_W'(H_DISPLAY);
  localparam logic [POS_W-1:0] V_DISP   = POS_W'(V_DISPLAY);
  localparam logic [POS_W-1:0] H_SS     = POS_W'(H_DISPLAY + H_FRONT);
  localparam logic [POS_W-1:0] H_SE     = POS_W'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [POS_W-1:0] V_SS     = POS_W'(V_DISPLAY + V_FRONT);
  localparam logic [POS_W-1:0] V_SE     = POS_W'(V_DISPLAY + V_FRONT + V_SYNC);
  localparam logic             H_POL    = (H_SYNC_POL != 0);
  localparam logic             V_POL    = (V_SYNC_POL != 0);
  localparam sync_bits_t       IDLE     = '{hs: ~H_POL, vs: ~V_POL, de: 1'b0};

  logic [DIV_W-1:0]   div_q, div_d;
  logic [POS_W-1:0]   hpos_q, hpos_d;
  logic [POS_W-1:0]   vpos_q, vpos_d;
  logic [FRAME_W-1:0] frame_q, frame_d;
  logic               pix_en;
  sync_bits_t         raw, dly;

  // Reset gates the tick so no strobe can leak out while counters are clearing.
  assign pix_en = !reset && vga.en && (div_q == DIV_LAST);

  always_comb begin
    div_d   = div_q;
    hpos_d  = hpos_q;
    vpos_d  = vpos_q;
    frame_d = frame_q;
    if (vga.en) div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    if (pix_en) begin
      if (hpos_q == H_LAST) begin
        hpos_d = '0;
        if (vpos_q == V_LAST) begin
          vpos_d  = '0;
          frame_d = frame_q + 1'b1;
        end else begin
          vpos_d = vpos_q + 1'b1;
        end
      end else begin
        hpos_d = hpos_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q   <= '0;
      hpos_q  <= '0;
      vpos_q  <= '0;
      frame_q <= '0;
    end else begin
      div_q   <= div_d;
      hpos_q  <= hpos_d;
      vpos_q  <= vpos_d;
      frame_q <= frame_d;
    end
  end

  // Vertical window looks at vpos only, so vsync edges land on hpos==0.
  assign raw.hs = ((hpos_q >= H_SS) && (hpos_q < H_SE)) ~^ H_POL;
  assign raw.vs = ((vpos_q >= V_SS) && (vpos_q < V_SE)) ~^ V_POL;
  assign raw.de = (hpos_q < H_DISP) && (vpos_q < V_DISP);

  vga_sync_delay #(
    .N (PIPE_DELAY),
    .W (3)
  ) u_sync_delay (
    .clk        (clk),
    .reset      (reset),
    .shift_en_i (pix_en),
    .rst_val_i  (IDLE),
    .d_i        (raw),
    .q_o        (dly)
  );

  assign vga.pix_en       = pix_en;
  assign vga.hpos         = hpos_q;
  assign vga.vpos         = vpos_q;
  assign vga.hsync        = dly.hs;
  assign vga.vsync        = dly.vs;
  assign vga.display_on   = dly.de;
  assign vga.line_start   = pix_en && (hpos_q == '0);
  assign vga.frame_start  = pix_en && (hpos_q == '0) && (vpos_q == '0);
  assign vga.vblank_start = pix_en && (hpos_q == '0) && (vpos_q == V_DISP);
  assign vga.frame_cnt    = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two instances on a tiny 14x7 raster (A: div 2, no delay,
// active-high syncs; B: div 1, two-tick delay, active-low syncs) checked against a tick-count model.
module tb_vga_timing_gen;

  localparam int HT = 14;
  localparam int VT = 7;
  localparam int FT = HT * VT;

  logic clk;
  logic reset;
  logic en;

  int total;
  int bad;

  // Model state: enabled clk cycles and pixel ticks since the last reset, per instance.
  int ecnt [2];
  int tcnt [2];
  int kdiv [2] = '{2, 1};
  int kpd  [2] = '{0, 2};
  bit kpol [2] = '{1'b1, 1'b0};

  vga_timing_gen_if #(.POS_W(10), .FRAME_W(8)) if_a ();
  vga_timing_gen_if #(.POS_W(10), .FRAME_W(8)) if_b ();

  assign if_a.en = en;
  assign if_b.en = en;

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(1), .V_SYNC_POL(1), .CLK_DIV(2), .PIPE_DELAY(0),
    .FRAME_W(8), .POS_W(10)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .vga   (if_a)
  );

  vga_timing_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
    .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_SYNC_POL(0), .V_SYNC_POL(0), .CLK_DIV(1), .PIPE_DELAY(2),
    .FRAME_W(8), .POS_W(10)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .vga   (if_b)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // {hsync, vsync, display_on} levels for raster tick t; t<0 means the idle levels.
  function automatic logic [2:0] decode(input int t, input bit pol);
    int  h, v;
    bit  hr, vr, dr;
    if (t < 0) return {~pol, ~pol, 1'b0};
    h  = t % HT;
    v  = (t / HT) % VT;
    hr = (h >= 8 + 2) && (h < 8 + 2 + 2);
    vr = (v >= 4 + 1) && (v < 4 + 1 + 1);
    dr = (h < 8) && (v < 4);
    return {hr ? pol : ~pol, vr ? pol : ~pol, dr};
  endfunction

  // ---------------- model ----------------
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        ecnt[k] = 0;
        tcnt[k] = 0;
      end else if (en) begin
        if (ecnt[k] % kdiv[k] == kdiv[k] - 1) tcnt[k] = tcnt[k] + 1;
        ecnt[k] = ecnt[k] + 1;
      end
    end
  end

  task automatic cmp_one(input int k, input string nm,
                         input logic pe, input logic ls, input logic fs, input logic vb,
                         input logic hs, input logic vs, input logic de,
                         input logic [9:0] h, input logic [9:0] v, input logic [7:0] fc);
    int         t, ph, pv;
    logic       epe;
    logic [2:0] e;
    t   = tcnt[k];
    ph  = t % HT;
    pv  = (t / HT) % VT;
    epe = !reset && en && (ecnt[k] % kdiv[k] == kdiv[k] - 1);
    e   = decode(t - kpd[k], kpol[k]);
    chk({nm, ".hpos"},         h,  ph);
    chk({nm, ".vpos"},         v,  pv);
    chk({nm, ".frame_cnt"},    fc, (t / FT) % 256);
    chk({nm, ".pix_en"},       pe, epe);
    chk({nm, ".line_start"},   ls, epe && ph == 0);
    chk({nm, ".frame_start"},  fs, epe && ph == 0 && pv == 0);
    chk({nm, ".vblank_start"}, vb, epe && ph == 0 && pv == 4);
    chk({nm, ".hsync"},        hs, e[2]);
    chk({nm, ".vsync"},        vs, e[1]);
    chk({nm, ".display_on"},   de, e[0]);
  endtask

  // ---------------- scoreboard compare (every cycle) ----------------
  always @(negedge clk) begin
    cmp_one(0, "a", if_a.pix_en, if_a.line_start, if_a.frame_start, if_a.vblank_start,
            if_a.hsync, if_a.vsync, if_a.display_on, if_a.hpos, if_a.vpos, if_a.frame_cnt);
    cmp_one(1, "b", if_b.pix_en, if_b.line_start, if_b.frame_start, if_b.vblank_start,
            if_b.hsync, if_b.vsync, if_b.display_on, if_b.hpos, if_b.vpos, if_b.frame_cnt);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_b(input int h, input int v, input string nm);
    int n;
    n = 0;
    while (!(if_b.hpos == h && if_b.vpos == v) && n < 300) begin
      step();
      n++;
    end
    chk({nm, "_reached"}, n < 300, 1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int vb_cnt;
    bit done;
    total = 0;
    bad   = 0;
    reset = 1'b1;
    en    = 1'b0;

    repeat (3) step();
    chk("rst_a_hpos",   if_a.hpos, 0);
    chk("rst_b_vpos",   if_b.vpos, 0);
    chk("rst_b_frame",  if_b.frame_cnt, 0);
    chk("rst_a_hsync",  if_a.hsync, 0);
    chk("rst_a_vsync",  if_a.vsync, 0);
    chk("rst_b_hsync",  if_b.hsync, 1);
    chk("rst_b_vsync",  if_b.vsync, 1);
    chk("rst_b_de",     if_b.display_on, 0);
    chk("rst_a_pix_en", if_a.pix_en, 0);

    // Cycle 0: B ticks immediately, A waits one clk.
    reset = 1'b0;
    en    = 1'b1;
    #1;
    chk("c0_a_pix_en",      if_a.pix_en, 0);
    chk("c0_b_pix_en",      if_b.pix_en, 1);
    chk("c0_b_frame_start", if_b.frame_start, 1);
    chk("c0_b_line_start",  if_b.line_start, 1);
    step();
    chk("c1_a_pix_en",      if_a.pix_en, 1);
    chk("c1_a_frame_start", if_a.frame_start, 1);
    chk("c1_a_line_start",  if_a.line_start, 1);
    chk("c1_b_hpos",        if_b.hpos, 1);

    // A frame period: next frame_start 196 clks later.
    n = 1;
    done = 0;
    while (!done && n < 400) begin
      step();
      n++;
      if (if_a.frame_start) done = 1;
    end
    chk("a_frame_period", n - 1, 196);
    chk("a_frame_cnt_1",  if_a.frame_cnt, 1);

    // B delayed syncs: window hpos 10..11 appears at hpos 12..13.
    wait_b(11, 0, "b_h11");
    chk("b_hsync_h11", if_b.hsync, 1);
    step();
    chk("b_hsync_h12", if_b.hsync, 0);
    step();
    chk("b_hsync_h13", if_b.hsync, 0);
    wait_b(2, 1, "b_de2");
    chk("b_de_h2", if_b.display_on, 1);

    // Pause at (5,2).
    wait_b(5, 2, "pause");
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("pause_hpos",       if_b.hpos, 5);
      chk("pause_vpos",       if_b.vpos, 2);
      chk("pause_pix_en",     if_b.pix_en, 0);
      chk("pause_line_start", if_a.line_start | if_b.line_start, 0);
    end
    en = 1'b1;
    step();
    chk("resume_hpos", if_b.hpos, 6);

    // One-clk reset at (11,5).
    wait_b(11, 5, "rst_point");
    reset = 1'b1;
    step();
    chk("mid_rst_hpos",   if_b.hpos, 0);
    chk("mid_rst_vpos",   if_b.vpos, 0);
    chk("mid_rst_frame",  if_b.frame_cnt, 0);
    chk("mid_rst_hsync",  if_b.hsync, 1);
    chk("mid_rst_vsync",  if_b.vsync, 1);
    chk("mid_rst_a_hs",   if_a.hsync, 0);
    chk("mid_rst_pix_en", if_b.pix_en, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_pix_en", if_b.pix_en, 1);
    chk("post_rst_fs",     if_b.frame_start, 1);
    chk("post_rst_ls",     if_b.line_start, 1);

    // 256 frames on B: frame_cnt wraps 255 -> 0, one vblank_start per frame.
    vb_cnt = 0;
    done   = 0;
    n      = 0;
    while (!done && n < 30000) begin
      step();
      n++;
      if (if_b.vblank_start) vb_cnt++;
      if (if_b.frame_cnt == 8'd255 && if_b.vpos == 6 && if_b.hpos == 13) done = 1;
    end
    chk("wrap_reached", done, 1);
    chk("wrap_vblanks", vb_cnt, 256);
    step();
    chk("wrap_frame_cnt", if_b.frame_cnt, 0);
    chk("wrap_vpos",      if_b.vpos, 0);
    chk("wrap_fs",        if_b.frame_start, 1);

    repeat (4) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
